fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  decode cannot accept; IF/ID register holds.
REQ-005 SHALL have port branch_taken  input  1  redirect fetch and flush IF/ID.
REQ-006 SHALL have port branch_target  input  32  redirect address; bits [1:0] ignored and treated as 00.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  32  word-aligned fetch address, equal to PC.
REQ-009 SHALL have port imem_ack  input  1  imem_rdata is valid for the imem_addr presented in the same cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have ports ifid_instr  output  32, ifid_pc4  output  32, ifid_valid  output  1: the IF/ID register.
REQ-012 SHALL have port op  output  6  equal to ifid_instr[31:26], feeding the main control decoder.

Function
REQ-013 SHALL implement FSM states IDLE, REQ and HOLD; imem_req=1 only in REQ.
REQ-014 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-015 In REQ with imem_ack=1 and stall=0: ifid_instr<=imem_rdata, ifid_pc4<=PC+4, ifid_valid<=1, PC<=PC+4, stay in REQ (one instruction per cycle at zero-wait memory).
REQ-016 In REQ with imem_ack=0 and stall=0: ifid_valid<=0, with ifid_instr and ifid_pc4 unchanged (bubble); PC unchanged.
REQ-017 In REQ with imem_ack=1 and stall=1: word and PC+4 captured into an internal hold buffer; IF/ID unchanged; PC<=PC+4; go to HOLD.
REQ-018 In REQ or HOLD with stall=1 and no branch: IF/ID SHALL hold all values.
REQ-019 In HOLD with stall=0: hold buffer moved to IF/ID with ifid_valid<=1; go to REQ.
REQ-020 branch_taken SHALL have priority over stall and imem_ack in any state except IDLE: PC<={branch_target[31:2],2'b00}, ifid_valid<=0, ifid_instr<=0, hold buffer discarded, same-cycle ack data discarded, go to REQ.
REQ-021 branch_taken in IDLE SHALL load the target into PC, and the FSM SHALL still go to REQ.
REQ-022 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-023 imem_addr SHALL equal PC in every cycle (registered, glitch-free) and SHALL be stable while imem_req=1 unless branch_taken.

Reset
REQ-024 On reset: PC=RESET_PC, state=IDLE, imem_req=0, ifid_valid=0, ifid_instr=0, ifid_pc4=0, op=0, hold buffer cleared, counters cleared.
REQ-025 Reset asserted mid-request or in HOLD SHALL abandon the transaction immediately; no partial IF/ID update.

Configuration
REQ-026 With macro FETCH_PERF_CNT_EN defined: outputs fetch_count (32 bits, +1 per IF/ID load with ifid_valid<=1) and stall_count (32 bits, +1 per cycle with stall=1) SHALL exist, wrap modulo 2^32, and clear on reset.
REQ-027 Without FETCH_PERF_CNT_EN: those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 RESET_PC=0x100, imem_ack tied high, 4 cycles after reset release -> ifid_pc4 = 0x104, 0x108, 0x10C with ifid_valid=1 each cycle; op = rdata[31:26].
REQ-029 imem_ack low for 2 cycles at PC=0x200 -> ifid_valid=0 for 2 cycles, imem_addr held at 0x200, then word loaded with ifid_pc4=0x204.
REQ-030 stall=1 with ack at PC=0x300, stall held 3 cycles -> IF/ID frozen, state HOLD, imem_req=0; on stall=0, ifid_pc4=0x304, then fetch resumes at 0x304.
REQ-031 branch_taken=1 with stall=1 and ack, branch_target=0x403 -> next cycle ifid_valid=0, ifid_instr=0, imem_addr=0x400.
REQ-032 PC=0xFFFFFFFC with ack -> ifid_pc4=0x0, next imem_addr=0x0; with FETCH_PERF_CNT_EN, fetch_count increments by exactly 1 per valid load and stall_count by 3 in REQ-030.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch stage. A PC register drives instruction-memory
//            requests, and fetched words are loaded into the IF/ID register.
//            Define FETCH_PERF_CNT_EN to add the fetch and stall counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [5:0]  op
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [31:0] C_PC_STEP = 32'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_load_valid;
    logic        w_unused_tgt_lsbs;

    assign w_pc_plus4        = pc_q + C_PC_STEP;
    assign w_target          = {branch_target[31:2], 2'b00};
    assign w_unused_tgt_lsbs = ^branch_target[1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        w_load_valid = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (branch_taken) begin
                    pc_d = w_target;
                end
            end
            REQ, HOLD: begin
                if (branch_taken) begin
                    // Redirect wins over stall and any word arriving this cycle.
                    pc_d         = w_target;
                    ifid_valid_d = 1'b0;
                    ifid_instr_d = 32'h0;
                    hold_instr_d = 32'h0;
                    hold_pc4_d   = 32'h0;
                    state_d      = REQ;
                end else if (state_q == HOLD) begin
                    if (!stall) begin
                        ifid_instr_d = hold_instr_q;
                        ifid_pc4_d   = hold_pc4_q;
                        ifid_valid_d = 1'b1;
                        w_load_valid = 1'b1;
                        state_d      = REQ;
                    end
                end else if (imem_ack) begin
                    pc_d = w_pc_plus4;
                    if (stall) begin
                        // Decode is busy: park the word so the request can retire.
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = w_pc_plus4;
                        state_d      = HOLD;
                    end else begin
                        ifid_instr_d = imem_rdata;
                        ifid_pc4_d   = w_pc_plus4;
                        ifid_valid_d = 1'b1;
                        w_load_valid = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            ifid_instr_q <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_pc4_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign op         = ifid_instr_q[31:26];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + {31'h0, w_load_valid};
        stall_count_d = stall_count_q + {31'h0, stall};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    logic w_unused_load_valid;
    assign w_unused_load_valid = w_load_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Scoreboard bench for fetch_stage with a zero-wait memory model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, stall, branch_taken, imem_ack;
    logic [31:0] branch_target;
    logic        imem_req, ifid_valid;
    logic [31:0] imem_addr, imem_rdata, ifid_instr, ifid_pc4;
    logic [5:0]  op;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count;
`endif

    logic [63:0] sb[$];
    logic [63:0] exp_e;
    logic [31:0] exp_pc;
    logic [31:0] frz_instr;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_loads = 0;
    int          n_stall = 0;

    fetch_stage #(.RESET_PC(C_RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .op           (op)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .stall_count  (stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic step();
        if (!reset && stall) n_stall++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; imem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({imem_req, ifid_valid, ifid_instr, ifid_pc4, op, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 6'h0, C_RESET_PC}) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b v=%b i=%h p=%h op=%h a=%h", imem_req, ifid_valid, ifid_instr, ifid_pc4, op, imem_addr);
        end
        reset = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cycle: got req=%b expected 0", imem_req);
        end
        step();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, C_RESET_PC}) begin
            n_fail++;
            $display("FAIL first_req: got req=%b a=%h expected 1 %h", imem_req, imem_addr, C_RESET_PC);
        end
        exp_pc = C_RESET_PC;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (imem_addr !== exp_pc) begin
                n_fail++;
                $display("FAIL stream_addr: got %h expected %h", imem_addr, exp_pc);
            end
            sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
            exp_pc = exp_pc + 32'd4;
            step();
            exp_e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
            n_loads++;
            n_cmp++;
            if ({ifid_valid, ifid_instr, ifid_pc4, op} !== {1'b1, exp_e, exp_e[63:58]}) begin
                n_fail++;
                $display("FAIL stream_load: got v=%b i=%h p=%h op=%h expected %h", ifid_valid, ifid_instr, ifid_pc4, op, exp_e);
            end
        end
    endtask

    task automatic test_ack_gap();
        branch_taken = 1'b1; branch_target = 32'h0000_0200;
        step();
        branch_taken = 1'b0;
        exp_pc = 32'h0000_0200;
        n_cmp++;
        if ({ifid_valid, ifid_instr, imem_addr, imem_req} !== {1'b0, 32'h0, exp_pc, 1'b1}) begin
            n_fail++;
            $display("FAIL gap_redirect: got v=%b i=%h a=%h req=%b", ifid_valid, ifid_instr, imem_addr, imem_req);
        end
        imem_ack = 1'b0;
        repeat (2) begin
            step();
            n_cmp++;
            if ({ifid_valid, ifid_instr, imem_addr, imem_req} !== {1'b0, 32'h0, exp_pc, 1'b1}) begin
                n_fail++;
                $display("FAIL gap_bubble: got v=%b i=%h a=%h req=%b expected a=%h", ifid_valid, ifid_instr, imem_addr, imem_req, exp_pc);
            end
        end
        imem_ack = 1'b1;
        sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
        step();
        exp_e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        n_loads++;
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, exp_e}) begin
            n_fail++;
            $display("FAIL gap_load: got v=%b i=%h p=%h expected %h", ifid_valid, ifid_instr, ifid_pc4, exp_e);
        end
    endtask

    task automatic test_stall();
        int stall_base;
        branch_taken = 1'b1; branch_target = 32'h0000_02FC;
        step();
        branch_taken = 1'b0;
        exp_pc = 32'h0000_02FC;
        frz_instr = mem_word(exp_pc);
        sb.push_back({frz_instr, 32'h0000_0300});
        exp_pc = 32'h0000_0300;
        step();
        exp_e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        n_loads++;
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, exp_e}) begin
            n_fail++;
            $display("FAIL pre_stall_load: got v=%b i=%h p=%h expected %h", ifid_valid, ifid_instr, ifid_pc4, exp_e);
        end
        stall_base = n_stall;
        stall = 1'b1;
        sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
        repeat (3) begin
            step();
            n_cmp++;
            if ({ifid_valid, ifid_instr, ifid_pc4, imem_req, imem_addr} !== {1'b1, frz_instr, 32'h0000_0300, 1'b0, exp_pc}) begin
                n_fail++;
                $display("FAIL stall_frozen: got v=%b i=%h p=%h req=%b a=%h", ifid_valid, ifid_instr, ifid_pc4, imem_req, imem_addr);
            end
        end
        n_cmp++;
        if (n_stall - stall_base !== 3) begin
            n_fail++;
            $display("FAIL stall_cycles: got %0d expected 3", n_stall - stall_base);
        end
        stall = 1'b0; imem_ack = 1'b0;
        step();
        exp_e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        n_loads++;
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc4, imem_req, imem_addr} !== {1'b1, exp_e, 1'b1, exp_pc}) begin
            n_fail++;
            $display("FAIL hold_release: got v=%b i=%h p=%h req=%b a=%h expected %h", ifid_valid, ifid_instr, ifid_pc4, imem_req, imem_addr, exp_e);
        end
        imem_ack = 1'b1;
        sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
        step();
        exp_e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        n_loads++;
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, exp_e}) begin
            n_fail++;
            $display("FAIL resume_load: got v=%b i=%h p=%h expected %h", ifid_valid, ifid_instr, ifid_pc4, exp_e);
        end
    endtask

    task automatic test_branch();
        stall = 1'b1; imem_ack = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0403;
        step();
        branch_taken = 1'b0;
        n_cmp++;
        if ({ifid_valid, ifid_instr, op, imem_addr, imem_req} !== {1'b0, 32'h0, 6'h0, 32'h0000_0400, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_flush: got v=%b i=%h op=%h a=%h req=%b", ifid_valid, ifid_instr, op, imem_addr, imem_req);
        end
        step();
        n_cmp++;
        if ({ifid_valid, imem_req, imem_addr} !== {1'b0, 1'b0, 32'h0000_0404}) begin
            n_fail++;
            $display("FAIL branch_hold_enter: got v=%b req=%b a=%h", ifid_valid, imem_req, imem_addr);
        end
        stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0500;
        step();
        branch_taken = 1'b0;
        exp_pc = 32'h0000_0500;
        n_cmp++;
        if ({ifid_valid, ifid_instr, imem_addr, imem_req, sb.size() == 0} !== {1'b0, 32'h0, exp_pc, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_in_hold: got v=%b i=%h a=%h req=%b sb=%0d", ifid_valid, ifid_instr, imem_addr, imem_req, sb.size());
        end
        sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
        step();
        exp_e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        n_loads++;
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, exp_e}) begin
            n_fail++;
            $display("FAIL post_branch_load: got v=%b i=%h p=%h expected %h", ifid_valid, ifid_instr, ifid_pc4, exp_e);
        end
    endtask

    task automatic test_back_to_back();
        logic ack;
        for (int i = 0; i < 24; i++) begin
            ack = 1'($urandom_range(0, 1));
            imem_ack = ack;
            if (ack) begin
                sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
                exp_pc = exp_pc + 32'd4;
            end
            step();
            if (ack) begin
                exp_e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
                n_loads++;
                n_cmp++;
                if ({ifid_valid, ifid_instr, ifid_pc4, imem_addr} !== {1'b1, exp_e, exp_pc}) begin
                    n_fail++;
                    $display("FAIL b2b_load: got v=%b i=%h p=%h a=%h expected %h a=%h", ifid_valid, ifid_instr, ifid_pc4, imem_addr, exp_e, exp_pc);
                end
            end else begin
                n_cmp++;
                if ({ifid_valid, imem_addr} !== {1'b0, exp_pc}) begin
                    n_fail++;
                    $display("FAIL b2b_bubble: got v=%b a=%h expected 0 %h", ifid_valid, imem_addr, exp_pc);
                end
            end
        end
        imem_ack = 1'b1;
    endtask

    task automatic test_wrap();
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        step();
        branch_taken = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        n_cmp++;
        if (imem_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL wrap_target: got %h expected %h", imem_addr, exp_pc);
        end
        sb.push_back({mem_word(exp_pc), 32'h0000_0000});
        exp_pc = 32'h0000_0000;
        step();
        exp_e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        n_loads++;
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc4, imem_addr} !== {1'b1, exp_e, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap_load: got v=%b i=%h p=%h a=%h expected %h a=0", ifid_valid, ifid_instr, ifid_pc4, imem_addr, exp_e);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if ({fetch_count, stall_count} !== {32'(n_loads), 32'(n_stall)}) begin
            n_fail++;
            $display("FAIL counters: got f=%0d s=%0d expected f=%0d s=%0d", fetch_count, stall_count, n_loads, n_stall);
        end
`endif
    endtask

    task automatic test_reset_mid();
        stall = 1'b1; imem_ack = 1'b1;
        step();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({imem_req, ifid_valid, ifid_instr, ifid_pc4, op, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 6'h0, C_RESET_PC}) begin
            n_fail++;
            $display("FAIL async_reset: got req=%b v=%b i=%h p=%h op=%h a=%h", imem_req, ifid_valid, ifid_instr, ifid_pc4, op, imem_addr);
        end
        sb.delete();
        n_loads = 0; n_stall = 0;
        stall = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        exp_pc = C_RESET_PC;
        sb.push_back({mem_word(exp_pc), exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
        step();
        exp_e = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        n_loads++;
        n_cmp++;
        if ({ifid_valid, ifid_instr, ifid_pc4} !== {1'b1, exp_e}) begin
            n_fail++;
            $display("FAIL after_reset_load: got v=%b i=%h p=%h expected %h", ifid_valid, ifid_instr, ifid_pc4, exp_e);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if ({fetch_count, stall_count} !== {32'(n_loads), 32'(n_stall)}) begin
            n_fail++;
            $display("FAIL counters_reset: got f=%0d s=%0d expected f=%0d s=%0d", fetch_count, stall_count, n_loads, n_stall);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ack_gap();
        test_stall();
        test_branch();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
